// File: rtl/ula_op_sequencer_if.sv
// Request, decoder-drive and result channels between the ULA sequencer and its neighbours.
// The slave modport is the sequencer's view; master is the requester/ULA/consumer side.
interface ula_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       a;
    logic             e;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [2:0]       out_op;
    logic             busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, res_in, out_ready,
        output in_ready, a, e, opa, opb, out_valid, out_res, out_op, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, res_in, out_ready,
        input  in_ready, a, e, opa, opb, out_valid, out_res, out_op, busy
    );
endinterface

// File: rtl/ula_op_sequencer.sv
// Accepts one op, holds the decoder select/enable for EXEC_CYCLES cycles,
// captures the enabled unit's result and offers it on a valid/ready channel.
module ula_op_sequencer #(
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ula_op_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       a_q, a_d;
    logic [2:0]       out_op_q, out_op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] out_res_q, out_res_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            a_q       <= 3'd0;
            out_op_q  <= 3'd0;
            opa_q     <= '0;
            opb_q     <= '0;
            out_res_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            out_op_q  <= out_op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            out_res_q <= out_res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        out_op_d  = out_op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        out_res_d = out_res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.in_op;
                    out_op_d = bus.in_op;
                    opa_d    = bus.in_a;
                    opb_d    = bus.in_b;
                    cnt_d    = CNT_LOAD;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // The unit has had EXEC_CYCLES cycles of stable operands when cnt hits 0.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_res_d = bus.res_in;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.e         = (state_q == EXEC);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.a         = a_q;
    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_op    = out_op_q;
endmodule

// File: tb/tb_ula_op_sequencer.sv
// Directed bench: one sequencer with EXEC_CYCLES=2 for handshake/back-pressure/reset,
// a second with EXEC_CYCLES=1 for the back-to-back opcode sweep.
module tb_ula_op_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ula_op_sequencer_if #(.WIDTH(8)) if2 ();
    ula_op_sequencer_if #(.WIDTH(8)) if1 ();

    ula_op_sequencer #(.WIDTH(8), .EXEC_CYCLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    ula_op_sequencer #(.WIDTH(8), .EXEC_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // ULA unit models: an adder behind dut2, op*0x11 behind dut1.
    assign if2.res_in = if2.opa + if2.opb;
    assign if1.res_in = {5'd0, if1.a} * 8'h11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if2.in_valid = 1'b0; if2.in_op = 3'd0; if2.in_a = 8'h00; if2.in_b = 8'h00; if2.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_op = 3'd0; if1.in_a = 8'h00; if1.in_b = 8'h00; if1.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(if2.in_ready), 32'd1);
        check("rst_e", 32'(if2.e), 32'd0);
        check("rst_busy", 32'(if2.busy), 32'd0);
        check("rst_out_valid", 32'(if2.out_valid), 32'd0);
        check("rst_a", 32'(if2.a), 32'd0);
        check("rst_out_res", 32'(if2.out_res), 32'd0);
        $display("txn reset: in_ready=%0d e=%0d busy=%0d", if2.in_ready, if2.e, if2.busy);

        // Single op 3, 0x12+0x34 = 0x46
        if2.in_valid = 1'b1; if2.in_op = 3'd3; if2.in_a = 8'h12; if2.in_b = 8'h34;
        tick();
        if2.in_valid = 1'b0;
        check("t1_exec1_e", 32'(if2.e), 32'd1);
        check("t1_exec1_a", 32'(if2.a), 32'd3);
        check("t1_exec1_opa", 32'(if2.opa), 32'h12);
        check("t1_exec1_opb", 32'(if2.opb), 32'h34);
        check("t1_exec1_in_ready", 32'(if2.in_ready), 32'd0);
        check("t1_exec1_busy", 32'(if2.busy), 32'd1);
        check("t1_exec1_out_valid", 32'(if2.out_valid), 32'd0);
        tick();
        check("t1_exec2_e", 32'(if2.e), 32'd1);
        check("t1_exec2_a", 32'(if2.a), 32'd3);
        check("t1_exec2_out_valid", 32'(if2.out_valid), 32'd0);
        tick();
        check("t1_done_e", 32'(if2.e), 32'd0);
        check("t1_done_out_valid", 32'(if2.out_valid), 32'd1);
        check("t1_done_out_res", 32'(if2.out_res), 32'h46);
        check("t1_done_out_op", 32'(if2.out_op), 32'd3);
        check("t1_done_busy", 32'(if2.busy), 32'd1);
        tick();
        check("t1_idle_out_valid", 32'(if2.out_valid), 32'd0);
        check("t1_idle_in_ready", 32'(if2.in_ready), 32'd1);
        check("t1_idle_busy", 32'(if2.busy), 32'd0);
        check("t1_idle_a_held", 32'(if2.a), 32'd3);
        check("t1_idle_opa_held", 32'(if2.opa), 32'h12);
        $display("txn op=3 a=12 b=34 -> out_res=%0h out_op=%0d", if2.out_res, if2.out_op);

        // Op 5 (1+2=3), then in_valid stays high with op 6 through EXEC and a stalled DONE
        if2.in_valid = 1'b1; if2.in_op = 3'd5; if2.in_a = 8'h01; if2.in_b = 8'h02;
        tick();
        if2.in_op = 3'd6; if2.in_a = 8'h10; if2.in_b = 8'h20; if2.out_ready = 1'b0;
        check("t2_exec1_a", 32'(if2.a), 32'd5);
        check("t2_exec1_e", 32'(if2.e), 32'd1);
        tick();
        check("t2_exec2_a", 32'(if2.a), 32'd5);
        check("t2_exec2_opa", 32'(if2.opa), 32'h01);
        tick();
        check("t2_done_out_valid", 32'(if2.out_valid), 32'd1);
        check("t2_done_out_res", 32'(if2.out_res), 32'h03);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3_stall%0d_out_valid", i), 32'(if2.out_valid), 32'd1);
            check($sformatf("t3_stall%0d_out_res", i), 32'(if2.out_res), 32'h03);
            check($sformatf("t3_stall%0d_out_op", i), 32'(if2.out_op), 32'd5);
            check($sformatf("t3_stall%0d_e", i), 32'(if2.e), 32'd0);
            check($sformatf("t3_stall%0d_in_ready", i), 32'(if2.in_ready), 32'd0);
            check($sformatf("t3_stall%0d_a", i), 32'(if2.a), 32'd5);
        end
        $display("txn op=5 a=01 b=02 stalled 5 cycles -> out_res=%0h out_op=%0d", if2.out_res, if2.out_op);
        if2.out_ready = 1'b1;
        tick();
        check("t2_hs_out_valid", 32'(if2.out_valid), 32'd0);
        check("t2_hs_in_ready", 32'(if2.in_ready), 32'd1);
        check("t2_hs_a_unchanged", 32'(if2.a), 32'd5);
        tick();
        check("t2_next_accept_e", 32'(if2.e), 32'd1);
        check("t2_next_accept_a", 32'(if2.a), 32'd6);
        check("t2_next_accept_opa", 32'(if2.opa), 32'h10);
        $display("txn op=6 accepted at first IDLE edge, a=%0d", if2.a);

        // Reset during the second EXEC cycle of op 6
        if2.in_valid = 1'b0;
        tick();
        check("t4_exec2_e", 32'(if2.e), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_e", 32'(if2.e), 32'd0);
        check("t4_rst_out_valid", 32'(if2.out_valid), 32'd0);
        check("t4_rst_busy", 32'(if2.busy), 32'd0);
        check("t4_rst_a", 32'(if2.a), 32'd0);
        check("t4_rst_in_ready", 32'(if2.in_ready), 32'd1);
        check("t4_rst_opa", 32'(if2.opa), 32'd0);
        check("t4_rst_out_res", 32'(if2.out_res), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t4_post%0d_out_valid", i), 32'(if2.out_valid), 32'd0);
        end
        $display("txn reset mid-EXEC: op 6 discarded");

        // Back-to-back sweep with EXEC_CYCLES=1
        for (int op = 0; op < 8; op++) begin
            if1.in_valid = 1'b1;
            if1.in_op = 3'(op);
            if1.in_a = 8'(op);
            if1.in_b = 8'(op);
            tick();
            check($sformatf("t5_op%0d_e", op), 32'(if1.e), 32'd1);
            check($sformatf("t5_op%0d_a", op), 32'(if1.a), 32'(op));
            check($sformatf("t5_op%0d_out_valid_exec", op), 32'(if1.out_valid), 32'd0);
            tick();
            check($sformatf("t5_op%0d_e_pulse", op), 32'(if1.e), 32'd0);
            check($sformatf("t5_op%0d_out_valid", op), 32'(if1.out_valid), 32'd1);
            check($sformatf("t5_op%0d_out_res", op), 32'(if1.out_res), 32'(op * 17));
            check($sformatf("t5_op%0d_out_op", op), 32'(if1.out_op), 32'(op));
            $display("txn sweep op=%0d -> out_res=%0h out_op=%0d", op, if1.out_res, if1.out_op);
            tick();
            check($sformatf("t5_op%0d_in_ready", op), 32'(if1.in_ready), 32'd1);
            check($sformatf("t5_op%0d_out_valid_low", op), 32'(if1.out_valid), 32'd0);
        end
        if1.in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ula_op_sequencer.md
# ula_op_sequencer

Sequencer stage directly upstream of the ULA 3-to-8 one-hot unit-select decoder. It accepts one operation at a time through a valid/ready handshake and latches the opcode and operands. It then drives the decoder's select (`a`) and enable (`e`) for a fixed number of execute cycles and captures the selected unit's result. The result is returned on a valid/ready output channel.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits.
- `EXEC_CYCLES`, default 2: number of cycles `e` is held high per operation; legal range 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  request accepted when high together with `in_valid` at a rising edge.
- `in_op`  input  3  opcode, 0..7.
- `in_a`, `in_b`  input  WIDTH each  operands.
- `a`  output  3  select to the decoder; this is the latched opcode.
- `e`  output  1  enable to the decoder.
- `opa`, `opb`  output  WIDTH each  latched operands presented to the ULA units.
- `res_in`  input  WIDTH  result from the enabled unit.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_res`  output  WIDTH  captured result.
- `out_op`  output  3  opcode that produced `out_res`.
- `busy`  output  1  high whenever the block is not in IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and DONE. A 4-bit down-counter `cnt` times EXEC.
- Output behaviour per state:
  - `in_ready` is high only in IDLE, decoded combinationally from state.
  - `e` is high only in EXEC.
  - `out_valid` is high only in DONE.
  - `busy` is high in EXEC and DONE.
- IDLE: when `in_valid && in_ready` at an edge:
  - latch `in_op` into `a` and `out_op`, latch `in_a`/`in_b` into `opa`/`opb`;
  - load `cnt` with EXEC_CYCLES-1 and go to EXEC.
- EXEC: if `cnt != 0`, decrement `cnt`. If `cnt == 0`, capture `res_in` into `out_res` and go to DONE.
- DONE: hold `out_res`/`out_op` stable. When `out_valid && out_ready` at an edge, go to IDLE.
- `in_valid` is ignored outside IDLE. No request is queued.
- Every opcode 0..7 is legal. The block never interprets the opcode; it only forwards it.
- `a`, `opa` and `opb` hold their last values after the operation; only `e` returns to 0.
- Reset, at any edge including mid-EXEC or mid-DONE:
  - state goes to IDLE and `cnt` goes to 0;
  - `a`, `out_op`, `opa`, `opb` and `out_res` clear to 0;
  - `e`, `out_valid` and `busy` go to 0, and `in_ready` is 1 after the reset edge;
  - the in-flight operation is discarded and never produces `out_valid`.
- `rst` has priority over any handshake sampled at the same edge.

## Timing
- Accept edge N: from edge N until edge N+EXEC_CYCLES, `e`=1 and `a`=op, i.e. exactly EXEC_CYCLES cycles.
- `res_in` is sampled at edge N+EXEC_CYCLES. The unit therefore gets EXEC_CYCLES cycles to settle its combinational result against stable `opa`/`opb`/`a`.
- `out_valid` rises after edge N+EXEC_CYCLES, so latency is EXEC_CYCLES cycles from acceptance.
- Output handshake at edge M: `out_valid` falls and `in_ready` rises after edge M. A new request can be accepted at edge M+1 at the earliest.
- With `out_ready` held high, peak throughput is one operation per EXEC_CYCLES+2 cycles.
- EXEC_CYCLES=1: EXEC lasts one cycle and `e` is a single-cycle pulse.
- Back-pressure: `out_ready` low holds DONE indefinitely. During that time `out_res`, `out_op` and `out_valid` are unchanged, `e`=0 and `in_ready`=0.

## Test plan
- Reset, then one request (`in_op`=3, `in_a`=8'h12, `in_b`=8'h34, EXEC_CYCLES=2, bench drives `res_in`=8'h46) with `out_ready`=1. Required: `e`=1 and `a`=3 for exactly 2 cycles; `out_valid` for 1 cycle with `out_res`=8'h46 and `out_op`=3; then `in_ready`=1.
- `in_valid` held high with a new op during EXEC and DONE. Required: no second acceptance and `a` unchanged until after the output handshake; the next op is accepted at the first IDLE edge.
- `out_ready` held low for 5 cycles in DONE. Required: `out_valid`=1 and `out_res` stable for all 5 cycles; `e`=0; `in_ready`=0.
- `rst` asserted during the second EXEC cycle. Required: the next cycle shows `e`=0, `out_valid`=0, `busy`=0, `a`=0, `in_ready`=1; no result is ever emitted for the discarded op.
- Sweep ops 0..7 back-to-back with EXEC_CYCLES=1, bench returning `res_in`=op*8'h11. Required: each `out_res`=op*8'h11 with matching `out_op`; `e` is a 1-cycle pulse per op; period is 3 cycles.
